// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port data memory.
// Port 0 (CPU) normally wins contention. Port 1 (DMA/display) is guaranteed
// a grant after STARVE_LIMIT consecutive lost cycles. Either port can lock
// the memory across back-to-back accesses.
module dmem_arbiter #(
  parameter int DBITS        = 32,
  parameter int ADDR_BITS    = 11,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 lock0,
  input  logic                 lock1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [DBITS-1:0]     wdata0,
  input  logic [DBITS-1:0]     wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [DBITS-1:0]     rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DBITS-1:0]     mem_wdata,
  input  logic [DBITS-1:0]     mem_rdata
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;
  logic       starve_hit;
  logic       acc0, acc1;

  assign starve_hit = (starve_q == LIMIT);

  // Grant decision: the lock owner is exclusive, otherwise port 0 has priority
  // unless port 1 has been starved for the full limit. No grants during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state_q)
        LOCK0: gnt0 = req0;
        LOCK1: gnt1 = req1;
        default: begin
          if (req0 && req1) begin
            gnt0 = !starve_hit;
            gnt1 = starve_hit;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  assign acc0 = req0 && gnt0;
  assign acc1 = req1 && gnt1;

  // Next-state: lock is taken or kept only by an accepted access with lock
  // set, so a dropped req or lock in a LOCK state falls back to ARB.
  // The starve counter keeps running while port 0 holds a lock.
  always_comb begin
    state_d = ARB;
    if (acc0 && lock0) begin
      state_d = LOCK0;
    end else if (acc1 && lock1) begin
      state_d = LOCK1;
    end

    starve_d = 4'd0;
    if (req1 && !gnt1) begin
      starve_d = (starve_q < LIMIT) ? starve_q + 4'd1 : starve_q;
    end

    rvalid0_d = acc0 && !we0;
    rvalid1_d = acc1 && !we1;
  end

  // Single state register for the arbiter FSM, starve counter and read-valid flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB;
      starve_q  <= 4'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // A read accepted just before reset must not surface while reset is high.
  assign rvalid0 = rvalid0_q && !reset;
  assign rvalid1 = rvalid1_q && !reset;
  assign rdata   = (rvalid0 || rvalid1) ? mem_rdata : '0;

  // Memory command mux: the accepted port drives the bus, idle bus is all zero.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (acc0) begin
      mem_en    = 1'b1;
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (acc1) begin
      mem_en    = 1'b1;
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of grants, locks, starvation and memory.
module tb_dmem_arbiter;
  localparam int DBITS = 32;
  localparam int ADDR_BITS = 11;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [ADDR_BITS-1:0] addr0 = '0, addr1 = '0;
  logic [DBITS-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
  logic [DBITS-1:0] rdata, mem_wdata;
  logic [DBITS-1:0] mem_rdata = '0;
  logic [ADDR_BITS-1:0] mem_addr;

  int total = 0;
  int bad = 0;

  dmem_arbiter #(.DBITS(DBITS), .ADDR_BITS(ADDR_BITS), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Initial memory image: recognisable per-address pattern, 0x010 holds DEADBEEF.
  function automatic logic [DBITS-1:0] init_val(input logic [ADDR_BITS-1:0] a);
    if (a == 11'h010) return 32'hDEADBEEF;
    return 32'hC0DE0000 | {21'd0, a};
  endfunction

  // Memory slave: one-cycle read latency, garbage on the read bus when idle.
  logic [DBITS-1:0] smem [2048];
  bit               swr  [2048];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      smem[mem_addr] <= mem_wdata;
      swr[mem_addr]  <= 1'b1;
    end
    if (mem_en && !mem_we) mem_rdata <= swr[mem_addr] ? smem[mem_addr] : init_val(mem_addr);
    else mem_rdata <= $urandom;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset();
    reset = 1; req0 = 1; req1 = 1; we0 = 1; addr0 = 11'h005; wdata0 = 32'h11112222;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({gnt0, gnt1, mem_en, mem_we, rvalid0, rvalid1} !== 6'b0) begin
        bad++;
        $display("FAIL reset_outputs c%0d: got %b expected 000000", c, {gnt0, gnt1, mem_en, mem_we, rvalid0, rvalid1});
      end
      next_cycle();
    end
    reset = 0; req0 = 0; req1 = 0; we0 = 0;
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, mem_en, rvalid0, rvalid1, rdata, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL idle_after_reset: got gnt=%b%b en=%b rv=%b%b rdata=%0h addr=%0h wdata=%0h expected all 0",
               gnt0, gnt1, mem_en, rvalid0, rvalid1, rdata, mem_addr, mem_wdata);
    end
    next_cycle();
    $display("txn reset sequence done");
  endtask

  task automatic test_single_read();
    req0 = 1; we0 = 0; addr0 = 11'h010;
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, mem_en, mem_we, mem_addr} !== {4'b1010, 11'h010}) begin
      bad++;
      $display("FAIL single_read_cmd: got gnt=%b%b en=%b we=%b addr=%0h expected 1 0 1 0 10",
               gnt0, gnt1, mem_en, mem_we, mem_addr);
    end
    next_cycle();
    req0 = 0;
    @(negedge clk);
    total++;
    if ({rvalid0, rvalid1, rdata} !== {2'b10, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL single_read_data: got rv=%b%b rdata=%0h expected 1 0 deadbeef", rvalid0, rvalid1, rdata);
    end
    next_cycle();
    $display("txn port0 read 010 -> deadbeef");
    go_idle();
  endtask

  task automatic test_starve();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 11'h004; addr1 = 11'h005;
    for (int c = 0; c < 15; c++) begin
      logic e1;
      e1 = (c % 5 == 4);
      @(negedge clk);
      total++;
      if ({gnt0, gnt1} !== {!e1, e1}) begin
        bad++;
        $display("FAIL starve_rotation c%0d: got gnt=%b%b expected %b%b", c, gnt0, gnt1, !e1, e1);
      end
      next_cycle();
      $display("txn contended cycle %0d granted port%0d", c, e1 ? 1 : 0);
    end
    go_idle();
  endtask

  task automatic test_lock1();
    req0 = 1; we0 = 0; addr0 = 11'h003; lock0 = 0;
    req1 = 1; we1 = 1; addr1 = 11'h7FF; wdata1 = 32'h5A5A5A5A; lock1 = 1;
    for (int c = 0; c < 9; c++) begin
      logic e0, e1;
      if (c == 7) begin req1 = 0; lock1 = 0; end
      e1 = (c >= 4 && c <= 6);
      e0 = (c <= 3 || c == 8);
      @(negedge clk);
      total++;
      if ({gnt0, gnt1} !== {e0, e1}) begin
        bad++;
        $display("FAIL lock1_grant c%0d: got gnt=%b%b expected %b%b", c, gnt0, gnt1, e0, e1);
      end
      if (e1) begin
        total++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 11'h7FF, 32'h5A5A5A5A}) begin
          bad++;
          $display("FAIL lock1_cmd c%0d: got en=%b we=%b addr=%0h wdata=%0h expected 1 1 7ff 5a5a5a5a",
                   c, mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      next_cycle();
      $display("txn lock1 cycle %0d", c);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    req0 = 1; we0 = 0; addr0 = 11'h001;
    req1 = 1; we1 = 0; addr1 = 11'h002;
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, mem_addr} !== {2'b10, 11'h001}) begin
      bad++;
      $display("FAIL b2b_first: got gnt=%b%b addr=%0h expected 10 1", gnt0, gnt1, mem_addr);
    end
    next_cycle();
    req0 = 0;
    @(negedge clk);
    total++;
    if ({gnt1, mem_addr, rvalid0, rvalid1, rdata} !== {1'b1, 11'h002, 2'b10, 32'hC0DE0001}) begin
      bad++;
      $display("FAIL b2b_second: got gnt1=%b addr=%0h rv=%b%b rdata=%0h expected 1 2 10 c0de0001",
               gnt1, mem_addr, rvalid0, rvalid1, rdata);
    end
    next_cycle();
    // port 0 write immediately followed by port 1 read of the same word
    req0 = 1; we0 = 1; addr0 = 11'h020; wdata0 = 32'h12345678;
    req1 = 1; we1 = 0; addr1 = 11'h020;
    @(negedge clk);
    total++;
    if ({rvalid0, rvalid1, rdata, gnt0, mem_we} !== {2'b01, 32'hC0DE0002, 2'b11}) begin
      bad++;
      $display("FAIL b2b_third: got rv=%b%b rdata=%0h gnt0=%b we=%b expected 01 c0de0002 1 1",
               rvalid0, rvalid1, rdata, gnt0, mem_we);
    end
    next_cycle();
    req0 = 0;
    @(negedge clk);
    total++;
    if ({gnt1, mem_en, mem_we, rvalid0, rvalid1} !== 5'b11000) begin
      bad++;
      $display("FAIL b2b_fourth: got gnt1=%b en=%b we=%b rv=%b%b expected 1 1 0 00", gnt1, mem_en, mem_we, rvalid0, rvalid1);
    end
    next_cycle();
    req1 = 0;
    @(negedge clk);
    total++;
    if ({rvalid0, rvalid1, rdata} !== {2'b01, 32'h12345678}) begin
      bad++;
      $display("FAIL b2b_raw: got rv=%b%b rdata=%0h expected 01 12345678", rvalid0, rvalid1, rdata);
    end
    next_cycle();
    $display("txn back-to-back sequence done");
    go_idle();
  endtask

  task automatic test_reset_mid();
    req0 = 1; we0 = 0; addr0 = 11'h010; lock0 = 0;
    req1 = 1; we1 = 0; addr1 = 11'h020; lock1 = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) lock0 = 1;
      @(negedge clk);
      total++;
      if ({gnt0, gnt1} !== 2'b10) begin
        bad++;
        $display("FAIL pre_reset c%0d: got gnt=%b%b expected 10", c, gnt0, gnt1);
      end
      next_cycle();
    end
    reset = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({gnt0, gnt1, mem_en, mem_we, rvalid0, rvalid1, rdata} !== '0) begin
        bad++;
        $display("FAIL mid_reset c%0d: got gnt=%b%b en=%b we=%b rv=%b%b rdata=%0h expected all 0",
                 c, gnt0, gnt1, mem_en, mem_we, rvalid0, rvalid1, rdata);
      end
      next_cycle();
    end
    reset = 0; lock0 = 0;
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, rvalid0} !== 3'b100) begin
      bad++;
      $display("FAIL post_reset_counter: got gnt=%b%b rv0=%b expected 10 0", gnt0, gnt1, rvalid0);
    end
    next_cycle();
    req0 = 0;
    @(negedge clk);
    total++;
    if ({gnt1, mem_addr} !== {1'b1, 11'h020}) begin
      bad++;
      $display("FAIL post_reset_arb: got gnt1=%b addr=%0h expected 1 20", gnt1, mem_addr);
    end
    next_cycle();
    $display("txn reset during pending read done");
    go_idle();
  endtask

  task automatic test_random();
    bit                   pend [2];
    logic                 pwe  [2];
    logic                 plk  [2];
    logic [ADDR_BITS-1:0] pad  [2];
    logic [DBITS-1:0]     pwd  [2];
    logic [DBITS-1:0]     ref_mem [int];
    int owner = -1;
    int losses = 0;
    logic erv0 = 0, erv1 = 0;
    logic [DBITS-1:0] erd = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; pwe[p] = 0; plk[p] = 0; pad[p] = '0; pwd[p] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic g [2];
      logic een, ewe;
      logic [ADDR_BITS-1:0] ead;
      logic [DBITS-1:0] ewd, exp_rdata;
      int w;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 3) != 0) begin
          pend[p] = 1;
          pwe[p] = 1'($urandom_range(0, 1));
          plk[p] = ($urandom_range(0, 3) == 0);
          pad[p] = 11'($urandom_range(0, 15));
          pwd[p] = $urandom;
        end
      end
      req0 = pend[0]; we0 = pwe[0]; lock0 = plk[0]; addr0 = pad[0]; wdata0 = pwd[0];
      req1 = pend[1]; we1 = pwe[1]; lock1 = plk[1]; addr1 = pad[1]; wdata1 = pwd[1];
      @(negedge clk);
      // Reference decision: owner is exclusive, else priority with starvation override.
      if (owner >= 0) begin
        g[0] = (owner == 0) && pend[0];
        g[1] = (owner == 1) && pend[1];
      end else if (pend[0] && pend[1]) begin
        g[1] = (losses >= LIMIT);
        g[0] = !g[1];
      end else begin
        g[0] = pend[0];
        g[1] = pend[1];
      end
      w = g[0] ? 0 : 1;
      een = g[0] || g[1];
      ewe = een ? pwe[w] : 1'b0;
      ead = een ? pad[w] : '0;
      ewd = een ? pwd[w] : '0;
      exp_rdata = (erv0 || erv1) ? erd : '0;
      total++;
      if ({gnt0, gnt1} !== {g[0], g[1]}) begin
        bad++;
        $display("FAIL rnd_gnt cyc%0d: got %b%b expected %b%b", cyc, gnt0, gnt1, g[0], g[1]);
      end
      total++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {een, ewe, ead, ewd}) begin
        bad++;
        $display("FAIL rnd_mem cyc%0d: got en=%b we=%b addr=%0h wd=%0h expected %b %b %0h %0h",
                 cyc, mem_en, mem_we, mem_addr, mem_wdata, een, ewe, ead, ewd);
      end
      total++;
      if ({rvalid0, rvalid1, rdata} !== {erv0, erv1, exp_rdata}) begin
        bad++;
        $display("FAIL rnd_read cyc%0d: got rv=%b%b rdata=%0h expected %b%b %0h",
                 cyc, rvalid0, rvalid1, rdata, erv0, erv1, exp_rdata);
      end
      // Advance the reference model.
      erv0 = g[0] && !pwe[0];
      erv1 = g[1] && !pwe[1];
      if (een) begin
        if (pwe[w]) ref_mem[int'(pad[w])] = pwd[w];
        else erd = ref_mem.exists(int'(pad[w])) ? ref_mem[int'(pad[w])] : init_val(pad[w]);
        $display("txn cyc%0d port%0d %s addr=%0h", cyc, w, pwe[w] ? "wr" : "rd", pad[w]);
      end
      owner = (g[0] && plk[0]) ? 0 : ((g[1] && plk[1]) ? 1 : -1);
      losses = (pend[1] && !g[1]) ? ((losses < LIMIT) ? losses + 1 : LIMIT) : 0;
      if (g[0]) pend[0] = 0;
      if (g[1]) pend[1] = 0;
      next_cycle();
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_starve();
    test_lock1();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DBITS, default 32, data width.
REQ-002 SHALL have parameter ADDR_BITS, default 11, word-address width (2048-word data memory).
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, max consecutive lost arbitrations for port 1 (range 1-15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports req0, req1  input  1 each  access request; port 0 = CPU, port 1 = secondary master (DMA/display).
REQ-007 SHALL have ports lock0, lock1  input  1 each  hold grant for the next cycle while asserted with req.
REQ-008 SHALL have ports we0, we1  input  1 each  write (1) / read (0).
REQ-009 SHALL have ports addr0, addr1  input  ADDR_BITS each  word address.
REQ-010 SHALL have ports wdata0, wdata1  input  DBITS each  write data.
REQ-011 SHALL have ports gnt0, gnt1  output  1 each  request accepted this cycle.
REQ-012 SHALL have ports rvalid0, rvalid1  output  1 each  read data valid.
REQ-013 SHALL have port rdata  output  DBITS  read data shared by both ports.
REQ-014 SHALL have ports mem_en, mem_we  output  1 each  memory strobe, write enable.
REQ-015 SHALL have ports mem_addr  output  ADDR_BITS, mem_wdata  output  DBITS  memory command.
REQ-016 SHALL have port mem_rdata  input  DBITS  memory read data, valid one cycle after a read strobe.

Function
REQ-017 SHALL grant at most one port per cycle; gnt is combinational from req and registered state, in the same cycle as req.
REQ-018 SHALL treat a transfer as accepted exactly when reqN & gntN; the master holds req/we/addr/wdata stable until accepted.
REQ-019 SHALL drive mem_en=1 and mem_we/mem_addr/mem_wdata from the granted port in the accepting cycle; otherwise mem_en=0, mem_we=0.
REQ-020 SHALL assert rvalidN for exactly one cycle, the cycle after an accepted read on port N; rdata = mem_rdata then; writes produce no rvalid.
REQ-021 SHALL implement FSM states ARB, LOCK0, LOCK1.
REQ-022 ARB: if only one req, grant it; if both, grant port 0 unless starve counter == STARVE_LIMIT, then grant port 1.
REQ-023 ARB -> LOCKN when port N is accepted with lockN=1; else stay in ARB.
REQ-024 LOCKN: grant only port N whenever reqN=1; other port gets no grant; return to ARB after any cycle in which reqN=0 or lockN=0.
REQ-025 Starve counter (4 bits): increments, saturating at STARVE_LIMIT, each cycle req1=1 and gnt1=0; clears to 0 when gnt1=1 or req1=0.
REQ-026 Starve counter SHALL also count during LOCK0, so port 1 wins the first contended ARB cycle after a long lock.
REQ-027 Back-to-back accepted accesses, any mix of ports and read/write, SHALL sustain one per cycle with no bubbles.
REQ-028 Read on port 0 followed immediately by accepted read on port 1 SHALL produce rvalid0 then rvalid1 on consecutive cycles, never both.

Reset
REQ-029 While reset=1 at a clock edge: state=ARB, starve counter=0, rvalid0=rvalid1=0 on the next cycle; gnt0, gnt1, mem_en, mem_we SHALL be 0 throughout any cycle with reset=1.
REQ-030 A read accepted in the cycle before reset asserts SHALL have its rvalid suppressed.
REQ-031 rdata, mem_addr, mem_wdata SHALL be 0 when not driven by an active access or rvalid.

Verification
REQ-032 Only req0 read addr 0x010, mem_rdata=0xDEADBEEF next cycle -> gnt0 same cycle, mem_en=1, mem_we=0, mem_addr=0x010; rvalid0=1, rdata=0xDEADBEEF one cycle later.
REQ-033 req0 and req1 held high continuously, STARVE_LIMIT=4 -> gnt0 cycles 0-3, gnt1 cycle 4, pattern repeats every 5 cycles.
REQ-034 Port 1 writes 0x5A5A5A5A to 0x7FF with lock1=1 for 3 accepts while req0=1 -> gnt1 3 consecutive cycles, gnt0=0; gnt0=1 the cycle after lock1 drops.
REQ-035 Both request, port 0 read 0x001 accepted, then port 1 read 0x002 -> rvalid0 then rvalid1 on consecutive cycles, each with its own data.
REQ-036 Read accepted, reset asserted next cycle for 2 cycles -> rvalid0=0, gnt/mem_en=0 during reset; first accept after reset back in ARB with counter 0.
